// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard and forwarding controller.
// A shadow tracker follows every instruction from EX (stage 1) to stage DEPTH.
// From it the block derives forwarding selects, load-use stalls, data-memory
// wait holds/bubbles and multi-cycle redirect flushes, and it counts stall cycles.
module hazard_scoreboard #(
   parameter int NREG       = 32,
   parameter int DEPTH      = 3,
   parameter int MEM_STAGE  = 2,
   parameter int BR_PENALTY = 1,
   parameter int CNTW       = 32,
   localparam int RW        = $clog2(NREG),
   localparam int SW        = $clog2(DEPTH + 1)
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              dec_valid,
   input  logic [RW-1:0]     dec_rs,
   input  logic [RW-1:0]     dec_rt,
   input  logic              dec_rs_used,
   input  logic              dec_rt_used,
   input  logic              dec_wr,
   input  logic [RW-1:0]     dec_dest,
   input  logic              dec_is_load,
   input  logic              dec_is_mem,
   input  logic              ex_redirect,
   input  logic              dhit,
   output logic              issue,
   output logic              dec_stall,
   output logic              fetch_flush,
   output logic              decode_flush,
   output logic [DEPTH-1:0]  stage_hold,
   output logic [DEPTH-1:0]  stage_bubble,
   output logic [SW-1:0]     fw_a,
   output logic [SW-1:0]     fw_b,
   output logic [1:0]        state,
   output logic [CNTW-1:0]   stall_cnt
);

   // Redirect countdown only needs to hold BR_PENALTY-1.
   localparam int CW = (BR_PENALTY > 1) ? $clog2(BR_PENALTY) : 1;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEMWAIT  = 2'd1,
      REDIRECT = 2'd2
   } state_t;

   state_t            cur_state;
   state_t            nxt_state;
   logic [CW-1:0]     flush_cnt;
   logic [CW-1:0]     nxt_flush_cnt;
   logic              flush;

   // Tracker: bit/element k-1 describes stage k. The mem flag is only
   // needed up to the memory stage, so it is kept no deeper than that.
   logic [DEPTH-1:0]     trk_v;
   logic [DEPTH-1:0]     trk_wr;
   logic [DEPTH-1:0]     trk_ld;
   logic [RW-1:0]        trk_dest [DEPTH];
   logic [MEM_STAGE-1:0] trk_mem;

   logic mem_wait;
   logic haz_a;
   logic haz_b;
   logic redir_take;

   // Find the youngest in-flight producer of src. Returns {hazard, stage}.
   // A load producer is a hazard until its data is available: before the
   // memory stage always, in the memory stage only while dhit is low.
   function automatic logic [SW:0] src_lookup(input logic [RW-1:0] src,
                                              input logic          used);
      logic [SW-1:0] k_hit;
      logic          haz;
      k_hit = '0;
      haz   = 1'b0;
      if (used && (src != '0)) begin
         // Walk oldest to youngest so the smallest matching stage wins.
         for (int k = DEPTH; k >= 1; k--) begin
            if (trk_v[k-1] && trk_wr[k-1] && (trk_dest[k-1] == src)) begin
               k_hit = SW'(k);
               haz   = trk_ld[k-1] &&
                       ((k < MEM_STAGE) || ((k == MEM_STAGE) && !dhit));
            end
         end
      end
      return {haz, k_hit};
   endfunction

   assign mem_wait   = trk_v[MEM_STAGE-1] & trk_mem[MEM_STAGE-1] & ~dhit;
   assign redir_take = ex_redirect & trk_v[0] & ~mem_wait;

   // Forwarding selects and per-source load-use hazards.
   always_comb begin
      {haz_a, fw_a} = src_lookup(dec_rs, dec_rs_used);
      {haz_b, fw_b} = src_lookup(dec_rt, dec_rt_used);
   end

   // Memory wait freezes stages 1..MEM_STAGE and drops a nop into the next one.
   always_comb begin
      stage_hold   = '0;
      stage_bubble = '0;
      for (int k = 0; k < DEPTH; k++) begin
         stage_hold[k]   = mem_wait && (k < MEM_STAGE);
         stage_bubble[k] = mem_wait && (k == MEM_STAGE);
      end
   end

   // Decode-side control: a flush overrides any stall.
   always_comb begin
      decode_flush = flush;
      fetch_flush  = flush;
      dec_stall    = dec_valid & (haz_a | haz_b | mem_wait) & ~flush;
      issue        = dec_valid & ~dec_stall & ~flush;
   end

   // Next-state logic: redirects are only honoured once stage 1 is free
   // to advance; the redirect countdown keeps running through a memory wait.
   always_comb begin
      nxt_state     = cur_state;
      nxt_flush_cnt = flush_cnt;
      flush         = 1'b0;
      case (cur_state)
         RUN, MEMWAIT: begin
            if (mem_wait) begin
               nxt_state = MEMWAIT;
            end else if (redir_take) begin
               flush         = 1'b1;
               nxt_flush_cnt = CW'(BR_PENALTY - 1);
               nxt_state     = (BR_PENALTY > 1) ? REDIRECT : RUN;
            end else begin
               nxt_state = RUN;
            end
         end
         REDIRECT: begin
            flush = 1'b1;
            if (flush_cnt <= CW'(1)) begin
               nxt_flush_cnt = '0;
               nxt_state     = RUN;
            end else begin
               nxt_flush_cnt = flush_cnt - CW'(1);
            end
         end
         default: begin
            nxt_state     = RUN;
            nxt_flush_cnt = '0;
         end
      endcase
   end

   // State register and redirect countdown.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         cur_state <= RUN;
         flush_cnt <= '0;
      end else begin
         cur_state <= nxt_state;
         flush_cnt <= nxt_flush_cnt;
      end
   end

   assign state = cur_state;

   // Tracker valid bits: hold, bubble, or shift down one stage.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         trk_v <= '0;
      end else begin
         if (!stage_hold[0]) begin
            trk_v[0] <= issue;
         end
         for (int k = 1; k < DEPTH; k++) begin
            if (stage_hold[k]) begin
               trk_v[k] <= trk_v[k];
            end else if (stage_bubble[k]) begin
               trk_v[k] <= 1'b0;
            end else begin
               trk_v[k] <= trk_v[k-1];
            end
         end
      end
   end

   // Tracker payload: meaningful only where the matching valid bit is set.
   always_ff @(posedge CLK) begin
      if (!stage_hold[0]) begin
         trk_wr[0]   <= dec_wr;
         trk_dest[0] <= dec_dest;
         trk_ld[0]   <= dec_is_load;
         trk_mem[0]  <= dec_is_mem;
      end
      for (int k = 1; k < DEPTH; k++) begin
         if (!stage_hold[k]) begin
            trk_wr[k]   <= trk_wr[k-1];
            trk_dest[k] <= trk_dest[k-1];
            trk_ld[k]   <= trk_ld[k-1];
         end
      end
      for (int k = 1; k < MEM_STAGE; k++) begin
         if (!stage_hold[k]) begin
            trk_mem[k] <= trk_mem[k-1];
         end
      end
   end

   // Saturating count of cycles in which decode was stalled.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         stall_cnt <= '0;
      end else if (dec_stall && (stall_cnt != '1)) begin
         stall_cnt <= stall_cnt + CNTW'(1);
      end
   end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard. Two instances share all inputs: the
// main one (CNTW=32) and a narrow-counter one (CNTW=4) for saturation.
module tb_hazard_scoreboard;

   localparam int NREG  = 32;
   localparam int DEPTH = 3;
   localparam int RW    = 5;
   localparam int SW    = 2;

   logic            CLK = 1'b0;
   logic            nRST;
   logic            dec_valid;
   logic [RW-1:0]   dec_rs, dec_rt, dec_dest;
   logic            dec_rs_used, dec_rt_used, dec_wr, dec_is_load, dec_is_mem;
   logic            ex_redirect, dhit;

   logic             issue, dec_stall, fetch_flush, decode_flush;
   logic [DEPTH-1:0] stage_hold, stage_bubble;
   logic [SW-1:0]    fw_a, fw_b;
   logic [1:0]       state;
   logic [31:0]      stall_cnt;

   logic             issue4, dec_stall4, fetch_flush4, decode_flush4;
   logic [DEPTH-1:0] stage_hold4, stage_bubble4;
   logic [SW-1:0]    fw_a4, fw_b4;
   logic [1:0]       state4;
   logic [3:0]       stall_cnt4;

   int n_vec = 0;
   int n_err = 0;

   always #5 CLK = ~CLK;

   hazard_scoreboard #(.NREG(NREG), .DEPTH(3), .MEM_STAGE(2), .BR_PENALTY(2), .CNTW(32)) dut (
      .CLK(CLK), .nRST(nRST), .dec_valid(dec_valid), .dec_rs(dec_rs), .dec_rt(dec_rt),
      .dec_rs_used(dec_rs_used), .dec_rt_used(dec_rt_used), .dec_wr(dec_wr),
      .dec_dest(dec_dest), .dec_is_load(dec_is_load), .dec_is_mem(dec_is_mem),
      .ex_redirect(ex_redirect), .dhit(dhit), .issue(issue), .dec_stall(dec_stall),
      .fetch_flush(fetch_flush), .decode_flush(decode_flush), .stage_hold(stage_hold),
      .stage_bubble(stage_bubble), .fw_a(fw_a), .fw_b(fw_b), .state(state),
      .stall_cnt(stall_cnt));

   hazard_scoreboard #(.NREG(NREG), .DEPTH(3), .MEM_STAGE(2), .BR_PENALTY(2), .CNTW(4)) dut4 (
      .CLK(CLK), .nRST(nRST), .dec_valid(dec_valid), .dec_rs(dec_rs), .dec_rt(dec_rt),
      .dec_rs_used(dec_rs_used), .dec_rt_used(dec_rt_used), .dec_wr(dec_wr),
      .dec_dest(dec_dest), .dec_is_load(dec_is_load), .dec_is_mem(dec_is_mem),
      .ex_redirect(ex_redirect), .dhit(dhit), .issue(issue4), .dec_stall(dec_stall4),
      .fetch_flush(fetch_flush4), .decode_flush(decode_flush4), .stage_hold(stage_hold4),
      .stage_bubble(stage_bubble4), .fw_a(fw_a4), .fw_b(fw_b4), .state(state4),
      .stall_cnt(stall_cnt4));

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic dec(input logic v, input logic [RW-1:0] rs, input logic rsu,
                      input logic [RW-1:0] rt, input logic rtu, input logic wr,
                      input logic [RW-1:0] dest, input logic ld, input logic mem);
      dec_valid   = v;
      dec_rs      = rs;
      dec_rs_used = rsu;
      dec_rt      = rt;
      dec_rt_used = rtu;
      dec_wr      = wr;
      dec_dest    = dest;
      dec_is_load = ld;
      dec_is_mem  = mem;
   endtask

   task automatic nop();
      dec(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic drain();
      nop();
      tick(); tick(); tick();
   endtask

   initial begin
      nRST = 1'b0;
      dhit = 1'b1;
      ex_redirect = 1'b0;
      dec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
      #3;
      check("rst_state", state, 2'd0);
      check("rst_cnt", stall_cnt, 0);
      check("rst_cnt4", stall_cnt4, 0);
      check("rst_issue", issue, 1);
      check("rst_issue4", issue4, 1);
      check("rst_stall", dec_stall, 0);
      check("rst_flush", {fetch_flush, decode_flush}, 0);
      check("rst_hold", stage_hold, 0);
      check("rst_bubble", stage_bubble, 0);
      check("rst_fw", {fw_a, fw_b}, 0);
      nop();
      @(negedge CLK) nRST = 1'b1;
      tick(); tick();

      // Forwarding distance 1, 2, 3 and beyond
      dec(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0);   // add r3,r1,r2
      #1 check("fwd_add_issue", issue, 1);
      tick();
      dec(1'b1, 5'd3, 1'b1, 5'd1, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0);   // sub r4,r3,r1
      #1 check("fwd_k1_a", fw_a, 1);
      check("fwd_k1_b", fw_b, 0);
      check("fwd_k1_stall", dec_stall, 0);
      tick();
      dec(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
      #1 check("fwd_k2_a", fw_a, 2);
      tick();
      dec(1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
      #1 check("fwd_k3_b", fw_b, 3);
      tick();
      dec(1'b1, 5'd3, 1'b1, 5'd3, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
      #1 check("fwd_gone", {fw_a, fw_b}, 0);
      tick();
      drain();

      // Load-use with hit: one stall then forward from MEM
      dec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1);   // lw r5
      #1 check("lu_lw_issue", issue, 1);
      tick();
      dec(1'b1, 5'd1, 1'b1, 5'd5, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0);
      #1 check("lu_stall", dec_stall, 1);
      check("lu_noissue", issue, 0);
      check("lu_fw_k1", fw_b, 1);
      tick();
      #1 check("lu_release", dec_stall, 0);
      check("lu_fw_k2", fw_b, 2);
      check("lu_issue", issue, 1);
      check("lu_cnt", stall_cnt, 1);
      tick();
      drain();

      // Memory wait: three miss cycles
      dec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1);
      tick();
      dec(1'b1, 5'd1, 1'b1, 5'd5, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0);
      #1 check("mw_k1_stall", dec_stall, 1);
      tick();
      dhit = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1 check("mw_state", state, (i == 0) ? 2'd0 : 2'd1);
         check("mw_hold", stage_hold, 3'b011);
         check("mw_bubble", stage_bubble, 3'b100);
         check("mw_stall", dec_stall, 1);
         check("mw_noissue", issue, 0);
         tick();
      end
      dhit = 1'b1;
      #1 check("mw_hit_state", state, 2'd1);
      check("mw_hit_stall", dec_stall, 0);
      check("mw_hit_issue", issue, 1);
      check("mw_hit_fw", fw_b, 2);
      check("mw_hit_hold", stage_hold, 0);
      tick();
      nop();
      #1 check("mw_run", state, 2'd0);
      check("mw_cnt", stall_cnt, 5);
      drain();

      // Redirect with BR_PENALTY=2
      dec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);   // branch
      tick();
      ex_redirect = 1'b1;
      dec(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
      #1 check("rd0_flush", {fetch_flush, decode_flush}, 2'b11);
      check("rd0_issue", issue, 0);
      check("rd0_stall", dec_stall, 0);
      check("rd0_state", state, 2'd0);
      tick();
      ex_redirect = 1'b0;
      #1 check("rd1_state", state, 2'd2);
      check("rd1_flush", {fetch_flush, decode_flush}, 2'b11);
      check("rd1_issue", issue, 0);
      tick();
      #1 check("rd2_state", state, 2'd0);
      check("rd2_flush", {fetch_flush, decode_flush}, 2'b00);
      check("rd2_issue", issue, 1);
      check("rd2_cnt", stall_cnt, 5);
      tick();
      drain();

      // Redirect held off while the memory stage waits
      dec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd9, 1'b1, 1'b1);   // lw r9
      tick();
      dec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);   // branch
      tick();
      nop();
      dhit = 1'b0;
      ex_redirect = 1'b1;
      #1 check("rdh0_flush", fetch_flush, 0);
      check("rdh0_state", state, 2'd0);
      check("rdh0_hold", stage_hold, 3'b011);
      tick();
      #1 check("rdh1_flush", {fetch_flush, decode_flush}, 2'b00);
      check("rdh1_state", state, 2'd1);
      tick();
      dhit = 1'b1;
      ex_redirect = 1'b0;
      tick();
      drain();

      // r0 destination and youngest-writer ordering
      dec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b1, 1'b1);   // lw r0
      tick();
      dec(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0);
      #1 check("r0_stall", dec_stall, 0);
      check("r0_fw", {fw_a, fw_b}, 0);
      check("r0_issue", issue, 1);
      tick();
      dec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0);
      tick();
      dec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0);
      tick();
      dec(1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
      #1 check("r7_fw_a", fw_a, 1);
      check("r7_fw_b", fw_b, 1);
      tick();
      drain();

      // Asynchronous reset in the middle of a memory wait
      dec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1);
      tick();
      dec(1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0);
      tick();
      dhit = 1'b0;
      tick(); tick(); tick();
      #1 check("ar_pre_state", state, 2'd1);
      check("ar_pre_cnt", stall_cnt, 9);
      check("ar_pre_cnt4", stall_cnt4, 9);
      nRST = 1'b0;
      #1 check("ar_state", state, 2'd0);
      check("ar_cnt", stall_cnt, 0);
      check("ar_cnt4", stall_cnt4, 0);
      check("ar_hold", stage_hold, 0);
      check("ar_bubble", stage_bubble, 0);
      check("ar_flush", {fetch_flush, decode_flush}, 0);
      check("ar_fw", {fw_a, fw_b}, 0);
      check("ar_stall", dec_stall, 0);
      check("ar_issue", issue, 1);

      // Saturation of the narrow counter
      nop();
      dhit = 1'b1;
      @(negedge CLK) nRST = 1'b1;
      tick();
      dec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1);
      tick();
      dec(1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0);
      dhit = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (i == 15) begin
            check("sat_cnt15", stall_cnt, 15);
            check("sat_cnt4_15", stall_cnt4, 15);
         end
      end
      check("sat_cnt20", stall_cnt, 20);
      check("sat_cnt4_hold", stall_cnt4, 15);
      dhit = 1'b1;
      nop();
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised hazard/forwarding controller for the pipeline's decode stage.
- Keeps a shadow tracker of every in-flight instruction after decode (stage 1 = EX through stage DEPTH).
- From the tracker it computes per-source forwarding selects, load-use stalls, memory-wait holds/bubbles, and multi-cycle branch-redirect flushes.
- Also maintains a saturating stall-cycle counter.

Parameters:
- NREG, 32: architectural register count; RW = $clog2(NREG).
- DEPTH, 3: tracked stages after decode (1=EX, 2=MEM, 3=WB); SW = $clog2(DEPTH+1).
- MEM_STAGE, 2: stage index of data-memory access; legal range 1 <= MEM_STAGE < DEPTH.
- BR_PENALTY, 1: cycles fetch/decode are flushed per redirect; must be >= 1.
- CNTW, 32: stall counter width.

Ports:
- CLK  in  1  clock
- nRST  in  1  reset
- dec_valid  in  1  decode holds an instruction
- dec_rs, dec_rt  in  RW  source registers
- dec_rs_used, dec_rt_used  in  1  source is actually read
- dec_wr, dec_dest  in  1, RW  writes a register / destination register
- dec_is_load, dec_is_mem  in  1  load / any data-memory op
- ex_redirect  in  1  stage-1 instruction is a taken branch or jump
- dhit  in  1  data memory completes the op in MEM_STAGE
- issue  out  1  decode instruction enters stage 1 this cycle
- dec_stall  out  1  hold PC and decode register
- fetch_flush, decode_flush  out  1  squash fetch / decode
- stage_hold  out  DEPTH  bit k-1 set: stage k holds
- stage_bubble  out  DEPTH  bit k-1 set: stage k loads a nop
- fw_a, fw_b  out  SW  0 = register file, k = result of the instruction in stage k
- state  out  2  RUN=0, MEMWAIT=1, REDIRECT=2
- stall_cnt  out  CNTW  saturating count of dec_stall cycles

Behaviour:
- Reset: one clock, CLK; reset is asynchronous and active-low, nRST.
  - Asserting nRST, including mid-operation, clears all tracker valids, sets state=RUN, flush counter=0, stall_cnt=0.
  - Consequently all combinational outputs are 0, except issue, which equals dec_valid.
- Tracker entry per stage: v, wr, dest, ld, mem.
- mem_wait = v & mem at MEM_STAGE & ~dhit.
- Pipeline advance:
  - mem_wait=0: entry k+1 <= entry k; entry 1 <= decode instruction if issue, else bubble.
  - mem_wait=1: stages 1..MEM_STAGE hold (stage_hold bits set); stage MEM_STAGE+1 gets a bubble (stage_bubble bit set); later stages advance.
  - If MEM_STAGE+1 > DEPTH, no bubble bit exists.
- Forwarding, per used source s != 0:
  - k = smallest stage index with v & wr & dest==s; fw = k, else fw = 0. Youngest producer wins.
  - Unused source, or s==0: fw = 0 and no hazard.
- Load-use hazard: the matching entry has ld, and either k < MEM_STAGE, or k == MEM_STAGE & ~dhit.
  - A load at MEM_STAGE with dhit=1 forwards with no stall.
- dec_stall = dec_valid & (hazard | mem_wait) & ~decode_flush.
- issue = dec_valid & ~dec_stall & ~decode_flush.
- On a stall, stage 1 receives a bubble only if mem_wait=0.
- FSM:
  - RUN:
    - If ex_redirect & v1 & ~mem_wait: assert fetch_flush and decode_flush this cycle, load counter with BR_PENALTY-1, then go to REDIRECT if the counter is nonzero, else stay in RUN.
    - Else if mem_wait: go to MEMWAIT.
  - MEMWAIT: exit to RUN on the cycle dhit=1.
    - ex_redirect is ignored while mem_wait=1; it is re-evaluated once stage 1 advances.
  - REDIRECT: fetch_flush = decode_flush = 1; counter decrements each cycle; return to RUN after the cycle in which counter == 1.
    - mem_wait during REDIRECT holds the stages but does not pause the counter.
- stall_cnt: +1 each cycle dec_stall=1; saturates at all-ones with no wrap.

Test Plan:
- Forwarding: issue "add r3" then "sub r4,r3,r1" the next cycle -> fw_a=1, dec_stall=0. A dependent instruction one cycle later instead sees fw_a=2; at k=3 it sees fw_b=3 (rt); 4+ cycles later, fw=0.
- Load-use: "lw r5", then a user of r5 (rt) with dhit=1 in the lw's MEM cycle -> exactly 1 stall cycle, then fw_b=2 and issue=1; stall_cnt=1.
- Memory wait: lw in MEM with dhit low 3 cycles -> state=MEMWAIT; stage_hold=3'b011 and stage_bubble=3'b100 for 3 cycles; the dependent instruction stays stalled; stall_cnt=3+1; RUN after dhit.
- Redirect: BR_PENALTY=2, ex_redirect with v1=1 -> fetch_flush/decode_flush high 2 cycles; state=REDIRECT for 1 cycle; issue=0 both cycles. Redirect held off while mem_wait=1.
- Register and ordering rules: r0 as dest of a load used next cycle -> no stall, fw=0. Two in-flight writers of r7 at stages 1 and 2 -> fw_a=1.
- Reset: drop nRST mid-MEMWAIT with stall_cnt=9 -> asynchronously state=0, stall_cnt=0, all holds/flushes/fw 0. Also force CNTW=4 saturation at 15.
